// File: rtl/riscv_pkg.sv
// Shared front-end types: PC width, bimodal counter encoding and BTB entry layout.
package riscv_pkg;

  localparam int unsigned PC_W  = 48;
  localparam int unsigned TGT_W = PC_W - 2;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_SNT = 2'b00;
  localparam bht_ctr_t CTR_WNT = 2'b01;
  localparam bht_ctr_t CTR_WT  = 2'b10;
  localparam bht_ctr_t CTR_ST  = 2'b11;

  // Tag is kept as a right-justified pc[47:2+idx] so the layout is index-width agnostic.
  typedef struct packed {
    logic             valid;
    logic [TGT_W-1:0] tag;
    logic [TGT_W-1:0] target;
  } btb_entry_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    res = ctr;
    if (taken && ctr != CTR_ST) begin
      res = ctr + 2'd1;
    end else if (!taken && ctr != CTR_SNT) begin
      res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous update and valid clear.
module btb
  import riscv_pkg::*;
#(
  parameter int unsigned ENTRIES = 64
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [PC_W-1:0]  lkp_pc_i,
  output logic             lkp_hit_c_o,
  output logic [PC_W-1:0]  lkp_target_c_o,
  input  logic             upd_en_i,
  input  logic [PC_W-1:0]  upd_pc_i,
  input  logic [TGT_W-1:0] upd_target_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  btb_entry_t       entry_q [ENTRIES];
  btb_entry_t       lkp_entry;
  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TGT_W-1:0] lkp_tag;
  logic [TGT_W-1:0] upd_tag;
  logic             unused_low_bits;

  function automatic logic [TGT_W-1:0] tag_of(input logic [PC_W-1:0] pc);
    return TGT_W'(pc >> (2 + IDX_W));
  endfunction

  assign lkp_idx   = lkp_pc_i[2 +: IDX_W];
  assign upd_idx   = upd_pc_i[2 +: IDX_W];
  assign lkp_tag   = tag_of(lkp_pc_i);
  assign upd_tag   = tag_of(upd_pc_i);
  assign lkp_entry = entry_q[lkp_idx];

  assign lkp_hit_c_o    = lkp_entry.valid && (lkp_entry.tag == lkp_tag);
  assign lkp_target_c_o = {lkp_entry.target, 2'b00};

  assign unused_low_bits = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

  // Only valid bits are reset; tag/target are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entry_q[i].valid <= 1'b0;
      end
    end else if (upd_en_i) begin
      entry_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target_i};
    end
  end

endmodule

// File: rtl/fetch_predictor.sv
// Fetch PC register with bimodal BHT + BTB next-PC prediction and execute-stage redirect/training.
module fetch_predictor
  import riscv_pkg::*;
#(
  parameter int unsigned     BHT_ENTRIES = 256,
  parameter int unsigned     BTB_ENTRIES = 64,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            stall_if,
  input  logic            br_valid_ex,
  input  logic            br_taken_ex,
  input  logic            mispred_ex,
  input  logic [PC_W-1:0] correct_pc_ex,
  input  logic [PC_W-1:0] index_pc_ex,
  output logic [PC_W-1:0] pc_if,
  output logic            pred_taken_if,
  output logic            flush_if
);

  localparam int unsigned BHT_IDX_W = $clog2(BHT_ENTRIES);

  bht_ctr_t             bht_q [BHT_ENTRIES];
  logic [PC_W-1:0]      pc_q;
  logic [PC_W-1:0]      pc_d;
  logic [BHT_IDX_W-1:0] pred_idx;
  logic [BHT_IDX_W-1:0] train_idx;
  logic                 btb_hit;
  logic [PC_W-1:0]      btb_target;
  logic                 redirect;
  logic                 unused_low_bits;

  assign pred_idx  = pc_q[2 +: BHT_IDX_W];
  assign train_idx = index_pc_ex[2 +: BHT_IDX_W];
  assign redirect  = br_valid_ex & mispred_ex;

  assign pc_if         = pc_q;
  assign flush_if      = n_reset & redirect;
  assign pred_taken_if = n_reset & btb_hit & bht_q[pred_idx][1];

  assign unused_low_bits = ^{index_pc_ex[1:0], correct_pc_ex[1:0]};

  btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk            (clk),
    .n_reset        (n_reset),
    .lkp_pc_i       (pc_q),
    .lkp_hit_c_o    (btb_hit),
    .lkp_target_c_o (btb_target),
    .upd_en_i       (br_valid_ex & br_taken_ex),
    .upd_pc_i       (index_pc_ex),
    .upd_target_i   (correct_pc_ex[PC_W-1:2])
  );

  // Redirect outranks stall, which outranks the predicted next PC.
  always_comb begin
    pc_d = pc_q + PC_W'(4);
    if (pred_taken_if) begin
      pc_d = btb_target;
    end
    if (redirect) begin
      pc_d = {correct_pc_ex[PC_W-1:2], 2'b00};
    end else if (stall_if) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      pc_q <= RESET_PC;
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_WNT;
      end
    end else begin
      pc_q <= pc_d;
      if (br_valid_ex) begin
        bht_q[train_idx] <= ctr_next(bht_q[train_idx], br_taken_ex);
      end
    end
  end

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed self-checking bench for fetch_predictor with hand-computed PCs and predictions.
module tb_fetch_predictor;

  logic        clk;
  logic        n_reset;
  logic        stall_if;
  logic        br_valid_ex;
  logic        br_taken_ex;
  logic        mispred_ex;
  logic [47:0] correct_pc_ex;
  logic [47:0] index_pc_ex;
  logic [47:0] pc_if;
  logic        pred_taken_if;
  logic        flush_if;

  int checks;
  int failures;

  fetch_predictor #(
    .BHT_ENTRIES (256),
    .BTB_ENTRIES (64),
    .RESET_PC    (48'h1000)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .stall_if      (stall_if),
    .br_valid_ex   (br_valid_ex),
    .br_taken_ex   (br_taken_ex),
    .mispred_ex    (mispred_ex),
    .correct_pc_ex (correct_pc_ex),
    .index_pc_ex   (index_pc_ex),
    .pc_if         (pc_if),
    .pred_taken_if (pred_taken_if),
    .flush_if      (flush_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_br();
    br_valid_ex   = 1'b0;
    br_taken_ex   = 1'b0;
    mispred_ex    = 1'b0;
    correct_pc_ex = '0;
    index_pc_ex   = '0;
  endtask

  // Resolve one branch without a redirect.
  task automatic train(input logic [47:0] pc, input logic taken, input logic [47:0] tgt);
    br_valid_ex   = 1'b1;
    br_taken_ex   = taken;
    mispred_ex    = 1'b0;
    index_pc_ex   = pc;
    correct_pc_ex = tgt;
    tick();
    clr_br();
  endtask

  // Steer fetch to pc via a not-taken mispredict on an unrelated PC (BHT idx 0).
  task automatic redirect_to(input logic [47:0] pc);
    br_valid_ex   = 1'b1;
    br_taken_ex   = 1'b0;
    mispred_ex    = 1'b1;
    index_pc_ex   = 48'h3000;
    correct_pc_ex = pc;
    tick();
    clr_br();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_reset  = 1'b0;
    stall_if = 1'b0;
    clr_br();

    // Reset
    tick();
    tick();
    chk("rst_pc", pc_if, 48'h1000);
    chk("rst_flush", 48'(flush_if), 48'h0);
    chk("rst_pred", 48'(pred_taken_if), 48'h0);
    n_reset = 1'b1;
    #1;
    chk("rel_pc", pc_if, 48'h1000);
    tick(); chk("seq_1004", pc_if, 48'h1004);
    tick(); chk("seq_1008", pc_if, 48'h1008);
    tick();
    tick(); chk("seq_1010", pc_if, 48'h1010);

    // Mispredict: 1008 taken to 2000 (ctr 01->10)
    br_valid_ex = 1'b1; br_taken_ex = 1'b1; mispred_ex = 1'b1;
    index_pc_ex = 48'h1008; correct_pc_ex = 48'h2000;
    #1;
    chk("mp_flush", 48'(flush_if), 48'h1);
    tick();
    chk("mp_pc", pc_if, 48'h2000);
    clr_br();
    #1;
    chk("mp_flush_off", 48'(flush_if), 48'h0);
    chk("pred_2000", 48'(pred_taken_if), 48'h0);

    // Second taken resolution (ctr 10->11), then restart at 1008 (low bits dropped)
    train(48'h1008, 1'b1, 48'h2000);
    redirect_to(48'h100A);
    chk("rd_pc_1008", pc_if, 48'h1008);
    chk("pred_1008_t", 48'(pred_taken_if), 48'h1);
    tick();
    chk("pred_jump", pc_if, 48'h2000);

    // Not-taken twice (ctr 11->10->01)
    train(48'h1008, 1'b0, 48'h0);
    train(48'h1008, 1'b0, 48'h0);
    redirect_to(48'h1008);
    chk("pred_1008_nt", 48'(pred_taken_if), 48'h0);

    // Stall hold, then redirect and training during stall
    stall_if = 1'b1;
    tick(); chk("stall_1", pc_if, 48'h1008);
    tick(); chk("stall_2", pc_if, 48'h1008);
    tick(); chk("stall_3", pc_if, 48'h1008);
    br_valid_ex = 1'b1; br_taken_ex = 1'b1; mispred_ex = 1'b1;
    index_pc_ex = 48'h1040; correct_pc_ex = 48'h3000;
    #1;
    chk("stall_flush", 48'(flush_if), 48'h1);
    tick();
    clr_br();
    chk("stall_rd_pc", pc_if, 48'h3000);
    tick();
    chk("stall_hold", pc_if, 48'h3000);
    redirect_to(48'h1040);
    chk("stall_rd2", pc_if, 48'h1040);
    chk("stall_train", 48'(pred_taken_if), 48'h1);
    stall_if = 1'b0;
    tick();
    chk("stall_tgt", pc_if, 48'h3000);

    // Aliasing: 1008 and 1108 share BTB index 2
    train(48'h1008, 1'b1, 48'h2000);
    train(48'h1108, 1'b1, 48'h4000);
    train(48'h1108, 1'b1, 48'h4000);
    redirect_to(48'h1008);
    chk("alias_miss", 48'(pred_taken_if), 48'h0);
    tick();
    chk("alias_seq", pc_if, 48'h100C);
    redirect_to(48'h1108);
    chk("alias_hit", 48'(pred_taken_if), 48'h1);
    tick();
    chk("alias_tgt", pc_if, 48'h4000);

    // Saturation: four takens then one not-taken leaves ctr at 10
    for (int i = 0; i < 4; i++) train(48'h1200, 1'b1, 48'h5000);
    train(48'h1200, 1'b0, 48'h0);
    redirect_to(48'h1200);
    chk("sat_pred", 48'(pred_taken_if), 48'h1);
    tick();
    chk("sat_tgt", pc_if, 48'h5000);
    train(48'h1200, 1'b0, 48'h0);
    redirect_to(48'h1200);
    chk("sat_down", 48'(pred_taken_if), 48'h0);

    // mispred without br_valid: no redirect, no training
    mispred_ex = 1'b1; br_taken_ex = 1'b1;
    index_pc_ex = 48'h1200; correct_pc_ex = 48'h6000;
    #1;
    chk("nv_flush", 48'(flush_if), 48'h0);
    tick();
    chk("nv_pc", pc_if, 48'h1204);
    clr_br();
    redirect_to(48'h1200);
    chk("nv_notrain", 48'(pred_taken_if), 48'h0);

    // Reset during mispredict
    n_reset = 1'b0;
    br_valid_ex = 1'b1; br_taken_ex = 1'b1; mispred_ex = 1'b1;
    index_pc_ex = 48'h1200; correct_pc_ex = 48'h7000;
    #1;
    chk("rst_mp_flush", 48'(flush_if), 48'h0);
    tick();
    chk("rst_mp_pc", pc_if, 48'h1000);
    n_reset = 1'b1;
    clr_br();
    #1;
    chk("rst_mp_pred", 48'(pred_taken_if), 48'h0);
    tick();
    chk("rst_mp_seq", pc_if, 48'h1004);

    // Wrap-around
    redirect_to(48'hFFFF_FFFF_FFFC);
    chk("wrap_pc", pc_if, 48'hFFFF_FFFF_FFFC);
    chk("wrap_pred", 48'(pred_taken_if), 48'h0);
    tick();
    chk("wrap_zero", pc_if, 48'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_predictor.md
# fetch_predictor

Fetch-side PC generator and branch predictor at the front of the RV64IMFD pipeline. Every cycle it holds the fetch PC and predicts the next one from a bimodal history table (BHT) and a direct-mapped branch target buffer (BTB). It is the receiving end of the execute stage's resolution interface: it redirects fetch on `mispred_ex` to `correct_pc_ex` and trains its tables at `index_pc_ex`.

## Interface
- `BHT_ENTRIES`, 256: number of 2-bit counters; power of 2.
- `BTB_ENTRIES`, 64: number of BTB entries; power of 2, ≤ BHT_ENTRIES.
- `RESET_PC`, 48'h0: fetch PC after reset; 4-byte aligned.
- `clk`  in  1  clock, rising edge.
- `n_reset`  in  1  reset, synchronous, active-low.
- `stall_if`  in  1  fetch back-pressure; hold `pc_if`.
- `br_valid_ex`  in  1  a branch or jump resolved in execute this cycle.
- `br_taken_ex`  in  1  resolved direction; qualified by `br_valid_ex`.
- `mispred_ex`  in  1  resolved next PC differs from predicted; qualified by `br_valid_ex`.
- `correct_pc_ex`  in  48  actual next PC of the resolved instruction: target if taken, PC+4 if not.
- `index_pc_ex`  in  48  PC of the resolved instruction.
- `pc_if`  out  48  current fetch PC.
- `pred_taken_if`  out  1  prediction for the instruction at `pc_if`.
- `flush_if`  out  1  squash younger instructions in fetch and decode.

## Operation
- Indexing: BHT index is `pc[2 +: log2(BHT_ENTRIES)]`. BTB index is `pc[2 +: log2(BTB_ENTRIES)]`. BTB tag is `pc[47 : 2+log2(BTB_ENTRIES)]`.
- BTB entry: valid bit, tag, and 46-bit target (`target[47:2]`). Bits [1:0] are implied zero.
- Prediction (combinational from `pc_if`):
  - Hit = BTB entry valid and tag matches.
  - `pred_taken_if` = hit and BHT counter ≥ 2.
  - next_pc = BTB target if `pred_taken_if`, else `pc_if + 4`, modulo 2^48.
- Next-PC priority, highest first:
  1. `n_reset` low → `RESET_PC`.
  2. `br_valid_ex & mispred_ex` → `{correct_pc_ex[47:2], 2'b00}`.
  3. `stall_if` → hold.
  4. Otherwise → next_pc.
- `flush_if` = `br_valid_ex & mispred_ex`, combinational. It is forced 0 while `n_reset` is low.
- `mispred_ex` without `br_valid_ex` is ignored, for both redirect and training.
- Training, on every `br_valid_ex` cycle regardless of `stall_if`:
  - BHT counter at `index_pc_ex` saturates: increment toward 3 if taken, decrement toward 0 if not taken.
  - If taken: write the BTB entry at `index_pc_ex` with valid=1, tag from `index_pc_ex`, target=`correct_pc_ex[47:2]`.
  - Not-taken never invalidates a BTB entry.
- Reset values:
  - `pc_if` = RESET_PC.
  - All BHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - `pred_taken_if` = 0, `flush_if` = 0.
- Reset held mid-operation overrides redirect, stall and training; no table writes occur while `n_reset` is low.

## Timing
- `pc_if` is registered.
- Redirect latency is 1 cycle: `correct_pc_ex` appears on `pc_if` the cycle after `flush_if` is high.
- Table writes take effect at the clock edge. A prediction in the same cycle as a write to the same index sees the old value; the next cycle sees the new one.
- Simultaneous redirect and stall: the redirect wins and `pc_if` updates.
- Wrap-around: `pc_if = 48'hFFFF_FFFF_FFFC` with no prediction → next `pc_if = 48'h0`.

## Structure
- Shared package `riscv_pkg` holds:
  - `PC_W = 48`
  - `bht_ctr_t` (2-bit) with constants `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`
  - `btb_entry_t` struct (valid, tag, target)
- Sub-module `btb`: direct-mapped array with one combinational read port (lookup) and one synchronous write port (update), plus synchronous valid clear on reset.
- BHT counter array and PC register live in the top level.

## Test plan
- Reset: hold `n_reset` low 2 cycles with RESET_PC=48'h1000 → `pc_if`=48'h1000, `flush_if`=0, `pred_taken_if`=0. Then `pc_if` steps 48'h1004, 48'h1008, ….
- Mispredict: at `pc_if`=48'h1010, drive `br_valid_ex`=1, `br_taken_ex`=1, `mispred_ex`=1, `index_pc_ex`=48'h1008, `correct_pc_ex`=48'h2000 → `flush_if`=1 that cycle, `pc_if`=48'h2000 next cycle.
- Training: resolve 48'h1008 taken to 48'h2000 twice (counter 01→10→11). Restart at 48'h1008 → `pred_taken_if`=1, next `pc_if`=48'h2000. Resolve not-taken twice → counter 01, `pred_taken_if`=0, but the BTB entry stays valid.
- Stall interaction: `stall_if`=1 for 3 cycles → `pc_if` is constant. A mispredict during the stall still redirects after 1 cycle, and training still occurs.
- Aliasing and saturation: two PCs with the same BTB index but different tags → the second write evicts the first, and the first then misses. Four consecutive taken resolutions leave the counter at 3, with no wrap to 0.
- Edge cases:
  - `mispred_ex`=1 with `br_valid_ex`=0 → no redirect and no table change.
  - `n_reset` low during a mispredict → `pc_if`=RESET_PC.
  - `pc_if` wraps from 48'hFFFF_FFFF_FFFC to 48'h0.
